// File: rtl/alu_chk_pkg.sv
// Shared constants and payload types for the ALU result checker.
package alu_chk_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned ST_W   = 2;

    localparam logic [OP_W-1:0] OP_AND = 2'b00;
    localparam logic [OP_W-1:0] OP_OR  = 2'b01;
    localparam logic [OP_W-1:0] OP_SHL = 2'b10;
    localparam logic [OP_W-1:0] OP_ADD = 2'b11;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'b00;
    localparam logic [ST_W-1:0] ST_RUN   = 2'b01;
    localparam logic [ST_W-1:0] ST_DRAIN = 2'b10;
    localparam logic [ST_W-1:0] ST_DONE  = 2'b11;

    // Observed result and recomputed expectation for one sampled vector
    typedef struct packed {
        logic [DATA_W-1:0] out;
        logic [DATA_W-1:0] exp;
    } alu_res_t;

    // Operands of one sampled vector, kept only for first-fail capture
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_opnd_t;

    function automatic logic st_is_busy(input logic [ST_W-1:0] st);
        return (st == ST_RUN) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational reference ALU: recomputes the expected result from opcode/a/b.
module alu_ref_model
    import alu_chk_pkg::*;
(
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] exp_c
);

    // Shift drops the MSB; add discards the carry by truncation to DATA_W
    always_comb begin
        exp_c = '0;
        case (opcode)
            OP_AND:  exp_c = a & b;
            OP_OR:   exp_c = a | b;
            OP_SHL:  exp_c = {a[DATA_W-2:0], 1'b0};
            OP_ADD:  exp_c = a + b;
            default: exp_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_result_checker.sv
// ALU transaction checker: samples vectors, compares against a reference, keeps counts.
// Optional macro ALU_CHK_FIRST_FAIL_EN adds first-mismatch capture outputs (ff_*).
module alu_result_checker
    import alu_chk_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MAX_VEC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              vld,
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
`ifdef ALU_CHK_FIRST_FAIL_EN
    ,
    output logic              ff_vld,
    output logic [OP_W-1:0]   ff_op,
    output logic [DATA_W-1:0] ff_a,
    output logic [DATA_W-1:0] ff_b,
    output logic [DATA_W-1:0] ff_out,
    output logic [DATA_W-1:0] ff_exp
`endif
);

    localparam int unsigned VCNT_W   = (MAX_VEC < 2) ? 1 : $clog2(MAX_VEC + 1);
    localparam int unsigned VEC_LAST = (MAX_VEC == 0) ? 0 : MAX_VEC - 1;

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   state_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              accept_c;
    logic              last_vec_c;
    logic              mismatch_c;
    logic [VCNT_W-1:0] vec_cnt;
    logic [DATA_W-1:0] exp_c;
    logic              s1_vld;
    alu_res_t          s1_res;

    // A start in the same cycle flushes, so the coincident vector is dropped
    assign accept_c   = vld && (state == ST_RUN) && !start;
    assign last_vec_c = (MAX_VEC != 0) && accept_c && (vec_cnt == VCNT_W'(VEC_LAST));
    assign mismatch_c = (s1_res.out != s1_res.exp);

    // Next-state and registered status decode
    always_comb begin
        state_nxt = state;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE:  state_nxt = ST_IDLE;
            ST_RUN:   if (stop || last_vec_c) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!s1_vld) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (start) begin
            state_nxt = ST_RUN;
        end
        busy_nxt = st_is_busy(state_nxt);
        done_nxt = (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Accepted-vector count for the auto-stop limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt <= '0;
        end else if (start) begin
            vec_cnt <= '0;
        end else if (accept_c && (MAX_VEC != 0)) begin
            vec_cnt <= vec_cnt + VCNT_W'(1);
        end
    end

    alu_ref_model u_ref (
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .exp_c  (exp_c)
    );

    // Stage 1: capture observed result with its expectation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_res <= '0;
        end else begin
            s1_vld <= accept_c;
            if (accept_c) begin
                s1_res <= '{out: out, exp: exp_c};
            end
        end
    end

    // Stage 2: compare and update saturating counters and the sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            err      <= 1'b0;
        end else if (start) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            err      <= 1'b0;
        end else if (s1_vld) begin
            if (!mismatch_c) begin
                if (pass_cnt != '1) begin
                    pass_cnt <= pass_cnt + CNT_W'(1);
                end
            end else begin
                err <= 1'b1;
                if (fail_cnt != '1) begin
                    fail_cnt <= fail_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef ALU_CHK_FIRST_FAIL_EN
    alu_opnd_t s1_opnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_opnd <= '0;
        end else if (accept_c) begin
            s1_opnd <= '{op: opcode, a: a, b: b};
        end
    end

    // Hold the first mismatch after start; later ones never overwrite it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_vld <= 1'b0;
            ff_op  <= '0;
            ff_a   <= '0;
            ff_b   <= '0;
            ff_out <= '0;
            ff_exp <= '0;
        end else if (start) begin
            ff_vld <= 1'b0;
            ff_op  <= '0;
            ff_a   <= '0;
            ff_b   <= '0;
            ff_out <= '0;
            ff_exp <= '0;
        end else if (s1_vld && mismatch_c && !ff_vld) begin
            ff_vld <= 1'b1;
            ff_op  <= s1_opnd.op;
            ff_a   <= s1_opnd.a;
            ff_b   <= s1_opnd.b;
            ff_out <= s1_res.out;
            ff_exp <= s1_res.exp;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Self-checking bench: three checker instances (default, MAX_VEC=3, CNT_W=2) on shared stimulus.
module tb_alu_result_checker;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic       stop   = 1'b0;
    logic       vld    = 1'b0;
    logic [1:0] opcode = 2'b00;
    logic [7:0] a      = 8'h00;
    logic [7:0] b      = 8'h00;
    logic [7:0] out    = 8'h00;

    logic [2:0]  busy, done, err;
    logic [15:0] pass0, fail0, pass1, fail1;
    logic [1:0]  pass2, fail2;

`ifdef ALU_CHK_FIRST_FAIL_EN
    logic [2:0] ff_vld;
    logic [1:0] ff_op  [3];
    logic [7:0] ff_a   [3];
    logic [7:0] ff_b   [3];
    logic [7:0] ff_out [3];
    logic [7:0] ff_exp [3];
`endif

    always #5 clk = ~clk;

    alu_result_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .vld(vld),
        .opcode(opcode), .a(a), .b(b), .out(out),
        .busy(busy[0]), .done(done[0]), .err(err[0]),
        .pass_cnt(pass0), .fail_cnt(fail0)
`ifdef ALU_CHK_FIRST_FAIL_EN
        , .ff_vld(ff_vld[0]), .ff_op(ff_op[0]), .ff_a(ff_a[0]), .ff_b(ff_b[0]),
        .ff_out(ff_out[0]), .ff_exp(ff_exp[0])
`endif
    );

    alu_result_checker #(.CNT_W(16), .MAX_VEC(3)) u_max (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .vld(vld),
        .opcode(opcode), .a(a), .b(b), .out(out),
        .busy(busy[1]), .done(done[1]), .err(err[1]),
        .pass_cnt(pass1), .fail_cnt(fail1)
`ifdef ALU_CHK_FIRST_FAIL_EN
        , .ff_vld(ff_vld[1]), .ff_op(ff_op[1]), .ff_a(ff_a[1]), .ff_b(ff_b[1]),
        .ff_out(ff_out[1]), .ff_exp(ff_exp[1])
`endif
    );

    alu_result_checker #(.CNT_W(2), .MAX_VEC(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .vld(vld),
        .opcode(opcode), .a(a), .b(b), .out(out),
        .busy(busy[2]), .done(done[2]), .err(err[2]),
        .pass_cnt(pass2), .fail_cnt(fail2)
`ifdef ALU_CHK_FIRST_FAIL_EN
        , .ff_vld(ff_vld[2]), .ff_op(ff_op[2]), .ff_a(ff_a[2]), .ff_b(ff_b[2]),
        .ff_out(ff_out[2]), .ff_exp(ff_exp[2])
`endif
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model, one slot per instance
    int m_max [3] = '{0, 3, 0};
    int m_sat [3] = '{65535, 65535, 3};
    bit m_run [3];
    int m_acc [3];
    int m_pass[3];
    int m_fail[3];
    bit m_err [3];
    bit m_ffv;
    int m_ffop, m_ffa, m_ffb, m_ffout, m_ffexp;

    function automatic int ref_alu(input int op, input int x, input int y);
        case (op)
            0:       return x & y;
            1:       return x | y;
            2:       return (x * 2) % 256;
            default: return (x + y) % 256;
        endcase
    endfunction

    task automatic model_clear(input int i);
        m_run[i] = 1'b0; m_acc[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_err[i] = 1'b0;
        if (i == 0) begin
            m_ffv = 1'b0; m_ffop = 0; m_ffa = 0; m_ffb = 0; m_ffout = 0; m_ffexp = 0;
        end
    endtask

    function automatic int get_pass(input int i);
        case (i)
            0:       return int'(pass0);
            1:       return int'(pass1);
            default: return int'(pass2);
        endcase
    endfunction

    function automatic int get_fail(input int i);
        case (i)
            0:       return int'(fail0);
            1:       return int'(fail1);
            default: return int'(fail2);
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Drive one cycle of stimulus and advance the model at transaction level
    task automatic cyc(input bit st, input bit sp, input bit v,
                       input int op, input int x, input int y, input int o);
        int e;
        start = st; stop = sp; vld = v;
        opcode = 2'(op); a = 8'(x); b = 8'(y); out = 8'(o);
        for (int i = 0; i < 3; i++) begin
            if (st) begin
                model_clear(i);
                m_run[i] = 1'b1;
            end else begin
                if (v && m_run[i]) begin
                    m_acc[i]++;
                    e = ref_alu(op, x, y);
                    if (o == e) begin
                        if (m_pass[i] < m_sat[i]) m_pass[i]++;
                    end else begin
                        if (m_fail[i] < m_sat[i]) m_fail[i]++;
                        m_err[i] = 1'b1;
                        if (i == 0 && !m_ffv) begin
                            m_ffv = 1'b1; m_ffop = op; m_ffa = x; m_ffb = y;
                            m_ffout = o; m_ffexp = e;
                        end
                    end
                    if (m_max[i] != 0 && m_acc[i] == m_max[i]) m_run[i] = 1'b0;
                end
                if (sp) m_run[i] = 1'b0;
            end
        end
        tick();
        start = 1'b0; stop = 1'b0; vld = 1'b0;
    endtask

    task automatic vec(input int op, input int x, input int y, input int o);
        cyc(1'b0, 1'b0, 1'b1, op, x, y, o);
    endtask

    task automatic rand_vec(input bit force_pass);
        int op, x, y, o;
        op = int'($urandom_range(0, 3));
        x  = int'($urandom_range(0, 255));
        y  = int'($urandom_range(0, 255));
        o  = (force_pass || $urandom_range(0, 1) == 1) ? ref_alu(op, x, y)
                                                       : int'($urandom_range(0, 255));
        vec(op, x, y, o);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_pass%0d", tag, i), get_pass(i), m_pass[i]);
            chk($sformatf("%s_fail%0d", tag, i), get_fail(i), m_fail[i]);
            chk($sformatf("%s_err%0d", tag, i), int'(err[i]), int'(m_err[i]));
        end
    endtask

    task automatic check_ff(input string tag);
`ifdef ALU_CHK_FIRST_FAIL_EN
        chk({tag, "_ffvld"}, int'(ff_vld[0]), int'(m_ffv));
        chk({tag, "_ffop"},  int'(ff_op[0]),  m_ffop);
        chk({tag, "_ffa"},   int'(ff_a[0]),   m_ffa);
        chk({tag, "_ffb"},   int'(ff_b[0]),   m_ffb);
        chk({tag, "_ffout"}, int'(ff_out[0]), m_ffout);
        chk({tag, "_ffexp"}, int'(ff_exp[0]), m_ffexp);
`else
        chk({tag, "_nofeat"}, int'(err[0]), int'(m_err[0]));
`endif
    endtask

    // Bounded wait for done on one instance, also checking the latency bound
    task automatic wait_done(input int idx, input string tag);
        int n = 0;
        while (done[idx] !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, int'(done[idx]), 1);
        chk({tag, "_lat_le3"}, int'(n <= 3), 1);
        chk({tag, "_busy"}, int'(busy[idx]), 0);
    endtask

    task automatic stop_and_wait(input string tag);
        cyc(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        wait_done(0, tag);
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) model_clear(i);

        // Reset state, then vld without start is ignored
        idle(2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
            chk($sformatf("rst_done%0d", i), int'(done[i]), 0);
        end
        check_all("rst");
        rst_n = 1'b1;
        idle(1);
        vec(0, 3, 5, 1);
        vec(3, 1, 1, 2);
        vec(1, 4, 4, 9);
        idle(2);
        check_all("idle_vld");
        chk("idle_busy", int'(busy[0]), 0);

        // Directed passing vectors
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        chk("run_busy", int'(busy[0]), 1);
        vec(0, 0, 5, 0);
        vec(1, 1, 4, 5);
        vec(2, 2, 3, 4);
        vec(3, 3, 2, 5);
        vec(0, 4, 1, 0);
        stop_and_wait("dir");
        check_all("dir");
        chk("dir_pass_lit", int'(pass0), 5);
        chk("dir_sat_lit", int'(pass2), 3);
        chk("dir_max_done", int'(done[1]), 1);

        // Carry discarded on add; shifted-out MSB produces a mismatch
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        vec(3, 8'hFF, 8'h01, 8'h00);
        vec(2, 8'h80, 8'h00, 8'h01);
        stop_and_wait("edge");
        check_all("edge");
        chk("edge_fail_lit", int'(fail0), 1);
        check_ff("edge");

        // Auto-stop after MAX_VEC on the limited instance, others keep running
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) rand_vec(1'b0);
        idle(3);
        chk("max_done", int'(done[1]), 1);
        chk("max_total", int'(pass1) + int'(fail1), 3);
        chk("max_other_busy", int'(busy[0]), 1);
        stop_and_wait("max");
        check_all("max");
        check_ff("max");

        // Saturation and start+stop in the same cycle
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) rand_vec(1'b1);
        stop_and_wait("sat");
        check_all("sat");
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ss_busy%0d", i), int'(busy[i]), 1);
            chk($sformatf("ss_done%0d", i), int'(done[i]), 0);
        end
        check_all("ss");
        stop_and_wait("ss_end");

        // Asynchronous reset in the middle of a run
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        vec(0, 8'hF0, 8'h0F, 8'h01);
        vec(1, 8'h10, 8'h01, 8'h00);
        idle(2);
        check_all("pre_rst");
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) model_clear(i);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mid_busy%0d", i), int'(busy[i]), 0);
            chk($sformatf("mid_done%0d", i), int'(done[i]), 0);
        end
        check_all("mid_rst");
        check_ff("mid_rst");
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_busy", int'(busy[0]), 0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        vec(3, 8'h10, 8'h20, 8'h30);
        stop_and_wait("post_rst");
        check_all("post_rst");

        // Randomized rounds with gaps
        for (int r = 0; r < 3; r++) begin
            cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
            for (int k = 0; k < 30; k++) begin
                rand_vec(1'b0);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            end
            stop_and_wait($sformatf("rnd%0d", r));
            check_all($sformatf("rnd%0d", r));
            check_ff($sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
